// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths and per-stage control layouts for pipe_stage_reg
package pipe_pkg;

    localparam int PIPE_CTRL_W_DEFAULT = 16;
    localparam int PIPE_CNT_W_DEFAULT  = 32;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] src_a_sel;
        logic [1:0] src_b_sel;
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [2:0] wb_sel;
    } ctrl_ex_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] size;
        logic       sign_ext;
        logic       reg_write;
        logic [2:0] wb_sel;
        logic [4:0] rd;
    } ctrl_mem_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [4:0] rd;
    } ctrl_wb_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - single valid+ctrl+data storage slot of a pipeline stage
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = PIPE_CTRL_W_DEFAULT,
    parameter int DATA_W     = 128,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              load,
    input  logic              empty,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            // Data is left alone unless asked, so a squash does not toggle the wide field
            valid <= 1'b0;
            ctrl  <= '0;
            if (CLEAR_DATA != 0) data <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end else if (empty) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic inter-stage register with optional skid slot, flush and stall counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = PIPE_CTRL_W_DEFAULT,
    parameter int DATA_W     = 128,
    parameter int SKID       = 1,
    parameter int CLEAR_DATA = 0,
    parameter int CNT_W      = PIPE_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic              accept;
    logic              issue;
    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [DATA_W-1:0] m_data;
    logic              m_load;
    logic              m_empty;
    logic [CTRL_W-1:0] m_ctrl_in;
    logic [DATA_W-1:0] m_data_in;
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;

    always_comb begin
        accept    = in_valid & in_ready;
        issue     = m_valid & out_ready;
        m_load    = issue ? (s_valid | accept) : (accept & ~m_valid);
        m_empty   = issue & ~m_load;
        // The skid entry is older than anything arriving now, so it refills the head first
        m_ctrl_in = (issue & s_valid) ? s_ctrl : in_ctrl;
        m_data_in = (issue & s_valid) ? s_data : in_data;
    end

    pipe_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk     (clk),
        .rstn    (rstn),
        .flush   (flush),
        .load    (m_load),
        .empty   (m_empty),
        .in_ctrl (m_ctrl_in),
        .in_data (m_data_in),
        .valid   (m_valid),
        .ctrl    (m_ctrl),
        .data    (m_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic s_load;
            logic s_empty;

            assign s_load  = ~issue & accept & m_valid;
            assign s_empty = issue & s_valid;
            // Taken straight from the skid flop: no path from out_ready to in_ready
            assign in_ready = ~s_valid;

            pipe_slot #(
                .CTRL_W     (CTRL_W),
                .DATA_W     (DATA_W),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_skid (
                .clk     (clk),
                .rstn    (rstn),
                .flush   (flush),
                .load    (s_load),
                .empty   (s_empty),
                .in_ctrl (in_ctrl),
                .in_data (in_data),
                .valid   (s_valid),
                .ctrl    (s_ctrl),
                .data    (s_data)
            );
        end else begin : g_noskid
            assign s_valid  = 1'b0;
            assign s_ctrl   = '0;
            assign s_data   = '0;
            assign in_ready = ~m_valid | out_ready;
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl & {CTRL_W{m_valid}};
    assign out_data  = m_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
